// File: rtl/riscv_mem_pkg.sv
// Shared types and sizing for the memory-side refill arbiter.
// Covers the FSM state and burst owner encodings, plus line-size derivation.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } owner_t;

    localparam int unsigned LINE_WORDS_DEF = 8;

    // Beat-index width for a power-of-two line size.
    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    localparam int unsigned OFF_W_DEF = off_w(LINE_WORDS_DEF);

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Cache/memory bus bundle for the refill arbiter.
// The master modport is the arbiter side; the slave modport is the cache/memory side.
interface cache_refill_arbiter_if
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
);
    localparam int unsigned OFF_W = off_w(LINE_WORDS);

    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic              DReq;
    logic              DWe;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemValid;

    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [OFF_W-1:0]  Beat;
    logic [DATA_W-1:0] RData;
    logic              IBeatValid;
    logic              DBeatValid;
    logic              IDone;
    logic              DDone;
    logic              IBusy;
    logic              DBusy;

    modport master (
        input  IReq, IAddr, DReq, DWe, DAddr, DWData, MemRData, MemValid,
        output MemReq, MemWe, MemAddr, MemWData, Beat, RData,
        output IBeatValid, DBeatValid, IDone, DDone, IBusy, DBusy
    );

    modport slave (
        output IReq, IAddr, DReq, DWe, DAddr, DWData, MemRData, MemValid,
        input  MemReq, MemWe, MemAddr, MemWData, Beat, RData,
        input  IBeatValid, DBeatValid, IDone, DDone, IBusy, DBusy
    );

endinterface

// File: rtl/burst_beat_counter.sv
// Beat index within a line burst; wraps naturally after the last beat.
module burst_beat_counter #(
    parameter int unsigned OFF_W = 3
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [OFF_W-1:0] o_beat,
    output logic             o_last
);

    logic [OFF_W-1:0] r_beat;

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clr) begin
            r_beat <= '0;
        end else if (i_inc) begin
            r_beat <= r_beat + OFF_W'(1);
        end
    end

    assign o_beat = r_beat;
    assign o_last = (r_beat == '1);

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one main-memory burst port between I-cache refill and D-cache refill/writeback.
// One line burst at a time; D wins simultaneous requests and bursts are never preempted.
module cache_refill_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  CpuRst_n,
    cache_refill_arbiter_if.master bus
);

    localparam int unsigned OFF_W = off_w(LINE_WORDS);

    state_t            r_state;
    owner_t            r_owner;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_i_done;
    logic              r_d_done;

    logic              w_burst;
    logic              w_inc;
    logic              w_clr;
    logic              w_last;
    logic [OFF_W-1:0]  w_beat;
    logic [ADDR_W-1:0] w_base;
    logic [DATA_W-1:0] w_wdata;
    logic              w_unused_addr;

    assign w_burst = (r_state == BURST);
    assign w_inc   = w_burst & bus.MemValid;
    assign w_clr   = ~w_burst;

    burst_beat_counter #(
        .OFF_W (OFF_W)
    ) u_beat (
        .clk     (clk),
        .i_rst_n (CpuRst_n),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_beat  (w_beat),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (!CpuRst_n) begin
            r_state   <= IDLE;
            r_owner   <= NONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.DReq) begin
                        r_state   <= BURST;
                        r_owner   <= OWN_D;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= bus.DWe;
                    end else if (bus.IReq) begin
                        r_state   <= BURST;
                        r_owner   <= OWN_I;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                    end
                end
                // Req dropping mid-burst is ignored; only the final beat ends the burst.
                BURST: begin
                    if (w_inc && w_last) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_i_done  <= (r_owner == OWN_I);
                        r_d_done  <= (r_owner == OWN_D);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_owner <= NONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= NONE;
                end
            endcase
        end
    end

    assign w_base        = (r_owner == OWN_D) ? bus.DAddr : bus.IAddr;
    assign w_unused_addr = ^w_base[OFF_W+1:0];
    assign w_wdata       = r_mem_we ? bus.DWData : '0;

    assign bus.MemReq     = r_mem_req;
    assign bus.MemWe      = r_mem_we;
    assign bus.MemAddr    = r_mem_req ? {w_base[ADDR_W-1:OFF_W+2], w_beat, 2'b00} : '0;
    assign bus.MemWData   = w_wdata;
    assign bus.Beat       = w_beat;
    assign bus.RData      = bus.MemRData;
    assign bus.IBeatValid = w_inc & (r_owner == OWN_I);
    assign bus.DBeatValid = w_inc & (r_owner == OWN_D);
    assign bus.IDone      = r_i_done;
    assign bus.DDone      = r_d_done;
    assign bus.IBusy      = bus.IReq & ~r_i_done;
    assign bus.DBusy      = bus.DReq & ~r_d_done;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Self-checking bench for cache_refill_arbiter: vector table plus beat scoreboard.
module tb_cache_refill_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    logic clk      = 1'b0;
    logic CpuRst_n = 1'b0;
    always #5 clk = ~clk;

    cache_refill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) bus ();

    cache_refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk      (clk),
        .CpuRst_n (CpuRst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        is_i;
        logic [2:0]  beat;
    } beat_t;

    typedef struct {
        string       name;
        logic        i_req;
        logic        d_req;
        logic        d_we;
        logic [31:0] addr;
        int unsigned mode;
        int unsigned exp_lat;
    } vec_t;

    beat_t       sb[$];
    vec_t        vecs[5];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned mem_mode = 0;
    int unsigned phase    = 0;
    logic        prev_i   = 1'b0;
    logic        prev_d   = 1'b0;

    // Writeback data depends on the beat index, as the D-cache would supply it.
    assign bus.DWData = 32'hC0DE_0000 | {29'd0, bus.Beat};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_burst(input logic is_i, input logic [31:0] addr, input logic we);
        for (int k = 0; k < int'(LW); k++) begin
            beat_t b;
            b.addr  = (addr & 32'hFFFF_FFE0) | 32'(k << 2);
            b.we    = we;
            b.wdata = we ? (32'hC0DE_0000 | 32'(k)) : 32'h0;
            b.is_i  = is_i;
            b.beat  = 3'(k);
            sb.push_back(b);
        end
    endfunction

    function automatic vec_t mk(input string n, input logic ir, input logic dr, input logic we,
                                input logic [31:0] a, input int unsigned m, input int unsigned lat);
        vec_t v;
        v.name = n; v.i_req = ir; v.d_req = dr; v.d_we = we;
        v.addr = a; v.mode = m; v.exp_lat = lat;
        return v;
    endfunction

    // Memory model: mode 0 idle, mode 1 a beat every cycle, mode 3 a beat every 3rd burst cycle.
    always @(posedge clk) begin
        #2;
        case (mem_mode)
            0: begin bus.MemValid = 1'b0; phase = 0; end
            1: begin bus.MemValid = 1'b1; phase = 0; end
            default: begin
                if (bus.MemReq) begin
                    bus.MemValid = (phase == 2);
                    phase = (phase == 2) ? 0 : phase + 1;
                end else begin
                    bus.MemValid = 1'b0;
                    phase = 0;
                end
            end
        endcase
        bus.MemRData = $urandom;
    end

    always @(negedge clk) begin : monitor
        beat_t e;
        if (bus.MemReq === 1'b1 && bus.MemValid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_unexpected: got beat at addr 0x%08h, required none", bus.MemAddr);
            end else begin
                e = sb.pop_front();
                chk("mem_addr",    bus.MemAddr,    e.addr);
                chk("mem_we",      32'(bus.MemWe), 32'(e.we));
                chk("mem_wdata",   bus.MemWData,   e.wdata);
                chk("beat_idx",    32'(bus.Beat),  32'(e.beat));
                chk("ibeat_valid", 32'(bus.IBeatValid), 32'(e.is_i));
                chk("dbeat_valid", 32'(bus.DBeatValid), 32'(!e.is_i));
                chk("rdata_route", bus.RData,      bus.MemRData);
            end
        end else if (bus.MemValid === 1'b1 && bus.MemReq === 1'b0) begin
            chk("stray_ibeat", 32'(bus.IBeatValid), 0);
            chk("stray_dbeat", 32'(bus.DBeatValid), 0);
        end
        if (prev_i) chk("idone_width", 32'(bus.IDone), 0);
        if (prev_d) chk("ddone_width", 32'(bus.DDone), 0);
        prev_i = (bus.IDone === 1'b1);
        prev_d = (bus.DDone === 1'b1);
    end

    task automatic run_vec(input vec_t v);
        int unsigned n;
        logic        got;
        mem_mode = v.mode;
        push_burst(v.i_req, v.addr, v.d_req & v.d_we);
        if (v.i_req) begin
            bus.IReq = 1'b1; bus.IAddr = v.addr;
        end else begin
            bus.DReq = 1'b1; bus.DWe = v.d_we; bus.DAddr = v.addr;
        end
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1; n++;
            if (bus.IDone || bus.DDone) got = 1'b1;
            else chk({v.name, "_busy"}, 32'(v.i_req ? bus.IBusy : bus.DBusy), 1);
        end
        chk({v.name, "_latency"},    n, v.exp_lat);
        chk({v.name, "_idone"},      32'(bus.IDone), 32'(v.i_req));
        chk({v.name, "_ddone"},      32'(bus.DDone), 32'(v.d_req));
        chk({v.name, "_sb_drained"}, sb.size(), 0);
        chk({v.name, "_busy_done"},  32'(v.i_req ? bus.IBusy : bus.DBusy), 0);
        @(posedge clk); #1;
        bus.IReq = 1'b0; bus.DReq = 1'b0; bus.DWe = 1'b0;
        chk({v.name, "_idle_memreq"}, 32'(bus.MemReq), 0);
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        int unsigned n;
        logic        got;

        bus.IReq = 1'b1; bus.DReq = 1'b1; bus.DWe = 1'b0;
        bus.IAddr = '0; bus.DAddr = '0;
        bus.MemValid = 1'b0; bus.MemRData = '0;

        vecs[0] = mk("i_refill",     1'b1, 1'b0, 1'b0, 32'h0000_1234, 1, 9);
        vecs[1] = mk("d_refill",     1'b0, 1'b1, 1'b0, 32'h0000_2FC4, 1, 9);
        vecs[2] = mk("d_writeback",  1'b0, 1'b1, 1'b1, 32'h8000_0040, 1, 9);
        vecs[3] = mk("i_slow_top",   1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 3, 25);
        vecs[4] = mk("d_wb_slow",    1'b0, 1'b1, 1'b1, 32'h0000_0000, 3, 25);

        // Reset held with both requests high: nothing may start.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_memreq", 32'(bus.MemReq), 0);
            chk("rst_idone",  32'(bus.IDone), 0);
            chk("rst_ddone",  32'(bus.DDone), 0);
            chk("rst_beat",   32'(bus.Beat), 0);
        end
        bus.IReq = 1'b0; bus.DReq = 1'b0;
        CpuRst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Simultaneous requests: D first, I waits with IBusy high.
        mem_mode = 1;
        push_burst(1'b0, 32'h0000_3000, 1'b0);
        push_burst(1'b1, 32'h0000_5000, 1'b0);
        bus.IReq = 1'b1; bus.IAddr = 32'h0000_5000;
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h0000_3000;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1; n++;
            chk("sim_ibusy_wait", 32'(bus.IBusy), 1);
            if (bus.DDone) got = 1'b1;
        end
        chk("sim_d_latency", n, 9);
        chk("sim_no_idone",  32'(bus.IDone), 0);
        @(posedge clk); #1;
        bus.DReq = 1'b0;
        chk("sim_gap_memreq", 32'(bus.MemReq), 0);
        @(posedge clk); #1;
        chk("sim_i_grant",  32'(bus.MemReq), 1);
        chk("sim_i_we",     32'(bus.MemWe), 0);
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1; n++;
            if (bus.IDone) got = 1'b1;
        end
        chk("sim_i_latency", n, 8);
        chk("sim_sb_drained", sb.size(), 0);
        @(posedge clk); #1;
        bus.IReq = 1'b0;
        @(posedge clk); #1;

        // Stray MemValid while idle.
        mem_mode = 1;
        repeat (3) begin @(posedge clk); #1; end
        chk("stray_beat_hold", 32'(bus.Beat), 0);
        chk("stray_memreq",    32'(bus.MemReq), 0);
        mem_mode = 0;
        @(posedge clk); #1;

        // Reset in the middle of an I burst, then a fresh burst.
        mem_mode = 1;
        push_burst(1'b1, 32'h0000_4000, 1'b0);
        bus.IReq = 1'b1; bus.IAddr = 32'h0000_4000;
        n = 0;
        while (n < 30 && !(bus.MemReq && bus.Beat == 3'd5)) begin
            @(posedge clk); #1; n++;
        end
        chk("rstmid_at_beat5", 32'(bus.Beat), 5);
        CpuRst_n = 1'b0;
        mem_mode = 0;
        @(posedge clk); #1;
        chk("rstmid_memreq",  32'(bus.MemReq), 0);
        chk("rstmid_no_done", 32'(bus.IDone), 0);
        chk("rstmid_beat",    32'(bus.Beat), 0);
        chk("rstmid_left",    sb.size(), 3);
        sb.delete();
        CpuRst_n = 1'b1;
        mem_mode = 1;
        push_burst(1'b1, 32'h0000_4000, 1'b0);
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1; n++;
            if (bus.IDone) got = 1'b1;
        end
        chk("rstmid_fresh_latency", n, 9);
        chk("rstmid_sb_drained",    sb.size(), 0);
        @(posedge clk); #1;
        bus.IReq = 1'b0;
        mem_mode = 0;
        repeat (2) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
